ima_adpcm_block_ctrl: RTL and testbench
=======================================

// Module: ima_adpcm_block_ctrl
// PURPOSE
//  Sequences one ima_adpcm_enc core to produce a block-framed IMA ADPCM byte stream.
//  The core is a sibling instance in the parent. This block:
//   - gates input samples into the core, one sample at a time;
//   - at the start of each block, captures the core's predictor and step index into a 4-byte header;
//   - packs 4-bit codes into bytes with a valid/ready byte output.
//  It sits between the sample source and the storage/packetiser.
// PARAMETERS
//  SAMPLES_PER_BLOCK  504  samples encoded per block; must be even and >=2 (504 gives a 256-byte block)
//  CNT_W              10   sample counter width; must satisfy 2**CNT_W > SAMPLES_PER_BLOCK
// PORTS
//  clock          in   1   clock
//  reset          in   1   reset, asynchronous, active-high
//  enable         in   1   start/continue blocks; sampled only in IDLE and BLK_END
//  inSamp         in   16  signed PCM sample from source
//  inValid        in   1   source sample valid
//  inReady        out  1   sample accepted when inValid&&inReady
//  encSamp        out  16  sample to core inSamp
//  encValid       out  1   one-cycle issue pulse to core inValid
//  encReady       in   1   core inReady
//  encPCM         in   4   core outPCM
//  encPCMValid    in   1   core outValid (one-cycle pulse)
//  encPredictSamp in   16  core outPredictSamp
//  encStepIndex   in   7   core outStepIndex
//  outByte        out  8   framed byte stream
//  outValid       out  1   outByte valid
//  outReady       in   1   sink ready; a byte transfers when outValid&&outReady
//  busy           out  1   high outside IDLE
//  blockDone      out  1   one-cycle pulse after the last byte of a block transfers
//  blockCount     out  16  completed blocks; wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; sample counter 0; nibble latch cleared.
//  State machine:
//   IDLE: if enable && encReady -> HDR.
//   HDR: emit 4 bytes in order:
//    - predictor [7:0], then predictor [15:8];
//    - {1'b0, stepIndex};
//    - 8'h00.
//   HDR values are captured from encPredictSamp/encStepIndex on HDR entry and held for all 4 bytes.
//   HDR advances one byte per transfer; after byte 3 transfers -> GET.
//   GET: inReady=1 only when the output register is empty (outValid==0) and encReady==1.
//    On accept: encSamp<=inSamp, pulse encValid for exactly 1 cycle -> WAIT_ENC.
//   WAIT_ENC: inReady=0, encValid=0; on encPCMValid -> PACK.
//   PACK:
//    - even sample index: latch the code as the low nibble, no byte emitted;
//    - odd sample index: load outByte={encPCM,lowNibble} and assert outValid.
//    - Then increment the counter. If counter==SAMPLES_PER_BLOCK -> BLK_END, else -> GET.
//   BLK_END: wait until the output register is empty.
//    Then pulse blockDone, increment blockCount, clear the counter.
//    If enable -> HDR, else -> IDLE.
//  Output register: single stage; outByte/outValid hold stable while outValid && !outReady.
//  Cleared on transfer unless reloaded in the same cycle.
//  Nibble order: the earlier sample goes in bits [3:0].
//  encPCM is latched in the cycle encPCMValid is high; encPCMValid outside WAIT_ENC is ignored.
//  Only one sample is ever in flight in the core, and a byte is emitted only when the output register is free.
//  The core's one-cycle-wide outValid therefore never needs to stall.
//  The header reflects the core state after the previous block's last sample is fully updated.
//  enable low mid-block: the block completes, then the controller returns to IDLE. Blocks are never truncated.
//  Reset mid-block: the partial block is discarded; the next block starts with a fresh header.
//  The parent must reset the core with the same reset.
//  Latency, sample accept to code: core latency (8 cycles) + 1 cycle to PACK.
// STRUCTURE
//  ima_adpcm_pkg:
//   - state enum (IDLE, HDR, GET, WAIT_ENC, PACK, BLK_END);
//   - HDR_BYTES=4, HDR_RSVD=8'h00;
//   - IMA_MAX_STEP_INDEX=88.
//  Sub-module ima_adpcm_nibble_packer: nibble latch plus output register with valid/ready.
//  The counter and FSM stay in this module. Core instantiation stays in the parent.
// TESTING
//  T1 Reset -> outValid=0, inReady=0, encValid=0, busy=0, blockCount=0 until enable.
//  T2 SPB=2, fresh reset, samples 1000,1000:
//   - block 1 bytes 00 00 00 00 77;
//   - block 2 header 2B 00 10 00;
//   - blockCount=1 after byte 5.
//  T3 SPB=4, samples all 0 -> 00 00 00 00 00 00; stepIndex stays 0; exactly one blockDone pulse.
//  T4 outReady=0 for 20 cycles during HDR byte 1 -> outByte stable at 8'h00, inReady=0, no encValid pulse.
//  T5 enable dropped after sample 1 of SPB=4 -> the remaining 3 samples are accepted, 2 data bytes follow, then IDLE with busy=0.
//  T6 Reset asserted in WAIT_ENC -> all outputs 0 the same cycle; after release and enable, the first byte out is header byte 0.

Source files
------------

// File: rtl/ima_adpcm_pkg.sv
// Shared types and constants for the IMA ADPCM block controller.
// Provides the FSM state encoding, the header payload and the header byte mux.
package ima_adpcm_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR      = 3'd1,
        GET      = 3'd2,
        WAIT_ENC = 3'd3,
        PACK     = 3'd4,
        BLK_END  = 3'd5
    } ctrlState_t;

    localparam int unsigned HDR_BYTES          = 4;
    localparam logic [7:0]  HDR_RSVD           = 8'h00;
    localparam int unsigned IMA_MAX_STEP_INDEX = 88;
    localparam int unsigned HDR_IDX_W          = 2;
    localparam int unsigned PCM_W              = 16;
    localparam int unsigned CODE_W             = 4;
    localparam int unsigned STEP_IDX_W         = 7;
    localparam int unsigned BYTE_W             = 8;

    // Core state snapshot taken at the start of every block.
    typedef struct packed {
        logic [PCM_W-1:0]      predictor;
        logic [STEP_IDX_W-1:0] stepIndex;
    } hdr_t;

    // Header layout: predictor LSB, predictor MSB, step index, reserved.
    function automatic logic [BYTE_W-1:0] hdrByte(input hdr_t hdr, input logic [HDR_IDX_W-1:0] idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = hdr.predictor[7:0];
            2'd1:    b = hdr.predictor[15:8];
            2'd2:    b = {1'b0, hdr.stepIndex};
            default: b = HDR_RSVD;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ima_adpcm_block_ctrl_nibble_packer.sv
// Nibble latch plus single-stage valid/ready output register.
// Even-indexed codes park in the low nibble; odd-indexed codes complete a byte.
module ima_adpcm_nibble_packer
    import ima_adpcm_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                rawValid,
    input  logic [BYTE_W-1:0]   rawByte,
    input  logic                nibbleValid,
    input  logic                nibbleOdd,
    input  logic [CODE_W-1:0]   nibble,
    input  logic                outReady,
    output logic [BYTE_W-1:0]   outByte,
    output logic                outValid
);

    logic [CODE_W-1:0] lowNibble;

    // The earlier sample of each pair lands in bits [3:0].
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lowNibble <= '0;
        end else if (nibbleValid && !nibbleOdd) begin
            lowNibble <= nibble;
        end
    end

    // A load wins over a clear so a same-cycle reload never drops a byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outByte  <= '0;
            outValid <= 1'b0;
        end else if (rawValid) begin
            outByte  <= rawByte;
            outValid <= 1'b1;
        end else if (nibbleValid && nibbleOdd) begin
            outByte  <= {nibble, lowNibble};
            outValid <= 1'b1;
        end else if (outValid && outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: rtl/ima_adpcm_block_ctrl.sv
// Block framing controller for one IMA ADPCM encoder core: issues samples one at a
// time, prefixes each block with a 4-byte state header and packs codes into bytes.
module ima_adpcm_block_ctrl
    import ima_adpcm_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_BLOCK = 504,
    parameter int unsigned CNT_W             = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PCM_W-1:0]      inSamp,
    input  logic                  inValid,
    output logic                  inReady,
    output logic [PCM_W-1:0]      encSamp,
    output logic                  encValid,
    input  logic                  encReady,
    input  logic [CODE_W-1:0]     encPCM,
    input  logic                  encPCMValid,
    input  logic [PCM_W-1:0]      encPredictSamp,
    input  logic [STEP_IDX_W-1:0] encStepIndex,
    output logic [BYTE_W-1:0]     outByte,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  busy,
    output logic                  blockDone,
    output logic [15:0]           blockCount
);

    localparam logic [HDR_IDX_W-1:0] HDR_LAST  = HDR_IDX_W'(HDR_BYTES - 1);
    localparam logic [CNT_W-1:0]     SAMP_LAST = CNT_W'(SAMPLES_PER_BLOCK - 1);

    ctrlState_t             state;
    ctrlState_t             nextState;
    logic [CNT_W-1:0]       sampCnt;
    logic [HDR_IDX_W-1:0]   hdrIdx;
    hdr_t                   hdrReg;
    logic [CODE_W-1:0]      pcmReg;

    logic                   hdrLoad;
    logic                   nibbleValid;
    logic                   blkFinish;
    logic                   accept;
    logic                   outXfer;
    logic                   hdrEntry;
    logic                   lastSamp;

    assign accept   = inValid && inReady;
    assign outXfer  = outValid && outReady;
    assign hdrEntry = (nextState == HDR) && (state != HDR);
    assign lastSamp = (sampCnt == SAMP_LAST);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (enable && encReady) begin
                    nextState = HDR;
                end
            end
            HDR: begin
                if (outXfer && (hdrIdx == HDR_LAST)) begin
                    nextState = GET;
                end
            end
            GET: begin
                if (accept) begin
                    nextState = WAIT_ENC;
                end
            end
            WAIT_ENC: begin
                if (encPCMValid) begin
                    nextState = PACK;
                end
            end
            PACK: begin
                nextState = lastSamp ? BLK_END : GET;
            end
            BLK_END: begin
                if (!outValid) begin
                    nextState = enable ? HDR : IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Per-state control strobes; loads only happen into an empty output register.
    always_comb begin
        inReady     = 1'b0;
        hdrLoad     = 1'b0;
        nibbleValid = 1'b0;
        blkFinish   = 1'b0;
        case (state)
            HDR:     hdrLoad     = !outValid;
            GET:     inReady     = !outValid && encReady;
            PACK:    nibbleValid = 1'b1;
            BLK_END: blkFinish   = !outValid;
            default: ;
        endcase
    end

    // Header snapshot is taken once on entry so all four bytes describe the same state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hdrReg <= '0;
            hdrIdx <= '0;
        end else if (hdrEntry) begin
            hdrReg <= '{predictor: encPredictSamp, stepIndex: encStepIndex};
            hdrIdx <= '0;
        end else if ((state == HDR) && outXfer) begin
            hdrIdx <= hdrIdx + HDR_IDX_W'(1);
        end
    end

    // Sample issue to the core and code capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            encSamp  <= '0;
            encValid <= 1'b0;
            pcmReg   <= '0;
        end else begin
            encValid <= accept;
            if (accept) begin
                encSamp <= inSamp;
            end
            if ((state == WAIT_ENC) && encPCMValid) begin
                pcmReg <= encPCM;
            end
        end
    end

    // Sample counter, block bookkeeping and busy flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sampCnt    <= '0;
            blockDone  <= 1'b0;
            blockCount <= '0;
            busy       <= 1'b0;
        end else begin
            blockDone <= blkFinish;
            busy      <= (nextState != IDLE);
            if (blkFinish) begin
                sampCnt    <= '0;
                blockCount <= blockCount + 16'd1;
            end else if (state == PACK) begin
                sampCnt <= sampCnt + CNT_W'(1);
            end
        end
    end

    ima_adpcm_nibble_packer uPacker (
        .clock       (clock),
        .reset       (reset),
        .rawValid    (hdrLoad),
        .rawByte     (hdrByte(hdrReg, hdrIdx)),
        .nibbleValid (nibbleValid),
        .nibbleOdd   (sampCnt[0]),
        .nibble      (pcmReg),
        .outReady    (outReady),
        .outByte     (outByte),
        .outValid    (outValid)
    );

endmodule

// File: tb/tb_ima_adpcm_block_ctrl.sv
// Self-checking bench: two controllers (2 and 4 samples per block) each paired with a
// behavioural 8-cycle IMA ADPCM core; output bytes are checked against a scoreboard.
module tb_ima_adpcm_block_ctrl;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] pred;
        logic [6:0]  idx;
    } encRes_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        enableCmd = 1'b0;
    logic [15:0] inSampCmd = '0;
    logic        inValidCmd = 1'b0;
    logic        outReadyCmd = 1'b0;

    logic [7:0]  obsByte [2];
    logic        obsValid [2];
    logic        obsInReady [2];
    logic        obsEncValid [2];
    logic [15:0] obsEncSamp [2];
    logic        obsBusy [2];
    logic        obsDone [2];
    logic [15:0] obsCount [2];

    int nChecks = 0;
    int nFails = 0;
    int doneCnt = 0;
    int bytesSeen = 0;
    logic [7:0] expQ [$];
    int srcQ [$];
    bit srcPend = 1'b0;
    int refPred = 0;
    int refIdx = 0;
    bit refOdd = 1'b0;
    logic [3:0] refLo = '0;

    int stepTab [89] = '{7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552,
        1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358, 5894, 6484,
        7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385,
        24623, 27086, 29794, 32767};
    int idxTab [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    always #5 clock = ~clock;

    // One IMA ADPCM step, multiply form of the predictor update.
    function automatic encRes_t imaEnc(input int pred, input int idx, input int samp);
        encRes_t r;
        int diff, mag, step, c, vp, np, ni;
        step = stepTab[idx];
        diff = samp - pred;
        mag  = (diff < 0) ? -diff : diff;
        c    = 0;
        if (mag >= step) begin c = 4; mag = mag - step; end
        if (mag >= (step >> 1)) begin c = c + 2; mag = mag - (step >> 1); end
        if (mag >= (step >> 2)) c = c + 1;
        vp = ((2 * c + 1) * step) >> 3;
        np = (diff < 0) ? pred - vp : pred + vp;
        if (np > 32767) np = 32767;
        if (np < -32768) np = -32768;
        ni = idx + idxTab[c];
        if (ni < 0) ni = 0;
        if (ni > 88) ni = 88;
        r.code = 4'((diff < 0) ? c + 8 : c);
        r.pred = 16'(np);
        r.idx  = 7'(ni);
        return r;
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g
        logic        encReady, encValid, encPCMValid;
        logic [3:0]  encPCM;
        logic [15:0] encSamp, cPred, cSamp;
        logic [6:0]  cIdx;
        logic        cBusy;
        logic [3:0]  cLat;
        encRes_t     cRes;

        ima_adpcm_block_ctrl #(.SAMPLES_PER_BLOCK(2 * (i + 1)), .CNT_W(10)) dut (
            .clock          (clock),
            .reset          (reset),
            .enable         (enableCmd && (sel == 1'(i))),
            .inSamp         (inSampCmd),
            .inValid        (inValidCmd && (sel == 1'(i))),
            .inReady        (obsInReady[i]),
            .encSamp        (encSamp),
            .encValid       (encValid),
            .encReady       (encReady),
            .encPCM         (encPCM),
            .encPCMValid    (encPCMValid),
            .encPredictSamp (cPred),
            .encStepIndex   (cIdx),
            .outByte        (obsByte[i]),
            .outValid       (obsValid[i]),
            .outReady       (outReadyCmd && (sel == 1'(i))),
            .busy           (obsBusy[i]),
            .blockDone      (obsDone[i]),
            .blockCount     (obsCount[i])
        );

        assign obsEncValid[i] = encValid;
        assign obsEncSamp[i]  = encSamp;
        assign encReady       = !cBusy;
        assign cRes           = imaEnc(int'($signed(cPred)), int'(cIdx), int'($signed(cSamp)));

        // Behavioural core: one sample in flight, result and state update 8 cycles later.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cPred <= '0; cIdx <= '0; cSamp <= '0; cBusy <= 1'b0; cLat <= '0;
                encPCM <= '0; encPCMValid <= 1'b0;
            end else begin
                encPCMValid <= 1'b0;
                if (encValid && !cBusy) begin
                    cBusy <= 1'b1; cLat <= '0; cSamp <= encSamp;
                end else if (cBusy) begin
                    if (cLat == 4'd7) begin
                        encPCM <= cRes.code; encPCMValid <= 1'b1;
                        cPred <= cRes.pred; cIdx <= cRes.idx; cBusy <= 1'b0;
                    end else begin
                        cLat <= cLat + 4'd1;
                    end
                end
            end
        end
    end

    task automatic checkVal(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pushHeader();
        expQ.push_back(8'(refPred));
        expQ.push_back(8'(refPred >>> 8));
        expQ.push_back({1'b0, 7'(refIdx)});
        expQ.push_back(8'h00);
    endtask

    // Drive one sample and, if asked, predict the byte it completes.
    task automatic addSample(input int s, input bit emit);
        encRes_t r;
        r = imaEnc(refPred, refIdx, s);
        refPred = int'($signed(r.pred));
        refIdx  = int'(r.idx);
        if (!refOdd) refLo = r.code;
        else if (emit) expQ.push_back({r.code, refLo});
        refOdd = !refOdd;
        srcQ.push_back(s);
    endtask

    task automatic waitDone(input int target, input string tag);
        for (int k = 0; k < 3000 && doneCnt < target; k++) tick();
        checkVal(tag, doneCnt, target);
    endtask

    task automatic startBlock();
        enableCmd = 1'b1;
        for (int k = 0; k < 50 && !obsBusy[sel]; k++) tick();
        enableCmd = 1'b0;
    endtask

    task automatic waitOutValid(input string tag);
        int k;
        for (k = 0; k < 200 && !obsValid[sel]; k++) tick();
        if (k == 200) checkVal(tag, 0, 1);
    endtask

    // Scoreboard: a byte transfers at the next rising edge when valid and ready are both high.
    always @(negedge clock) begin
        if (!reset) begin
            if (obsValid[sel] && outReadyCmd) begin
                bytesSeen++;
                if (expQ.size() == 0) checkVal("byteUnexpected", expQ.size(), 1);
                else checkVal("outByte", obsByte[sel], expQ.pop_front());
            end
            if (obsDone[sel]) doneCnt++;
        end
    end

    // Sample source: holds inValid with the queue head until accepted.
    always @(negedge clock) begin
        if (reset) begin
            srcPend = 1'b0;
            inValidCmd = 1'b0;
        end else begin
            if (srcPend && srcQ.size() > 0) void'(srcQ.pop_front());
            inValidCmd = (srcQ.size() > 0);
            if (srcQ.size() > 0) inSampCmd = 16'(srcQ[0]);
            srcPend = inValidCmd && obsInReady[sel];
        end
    end

    initial begin
        int b0;
        // T1: reset state
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        checkVal("rstOutValid", obsValid[0], 0);
        checkVal("rstInReady", obsInReady[0], 0);
        checkVal("rstEncValid", obsEncValid[0], 0);
        checkVal("rstBusy", obsBusy[0], 0);
        checkVal("rstBlockCount", obsCount[0], 0);

        // T2: two samples per block, header carries the updated core state
        sel = 1'b0;
        outReadyCmd = 1'b1;
        expQ.push_back(8'h00); expQ.push_back(8'h00); expQ.push_back(8'h00); expQ.push_back(8'h00);
        expQ.push_back(8'h77);
        addSample(1000, 1'b0); addSample(1000, 1'b0);
        expQ.push_back(8'h2B); expQ.push_back(8'h00); expQ.push_back(8'h10); expQ.push_back(8'h00);
        addSample(1000, 1'b1); addSample(1000, 1'b1);
        enableCmd = 1'b1;
        waitDone(1, "t2Block1");
        checkVal("t2Bytes1", bytesSeen, 5);
        checkVal("t2Count1", obsCount[0], 1);
        enableCmd = 1'b0;
        waitDone(2, "t2Block2");
        repeat (3) tick();
        checkVal("t2Count2", obsCount[0], 2);
        checkVal("t2Idle", obsBusy[0], 0);

        // T3: four zero samples on the second controller
        sel = 1'b1; doneCnt = 0; refPred = 0; refIdx = 0; refOdd = 1'b0;
        pushHeader();
        for (int k = 0; k < 4; k++) addSample(0, 1'b1);
        startBlock();
        waitDone(1, "t3Block");
        repeat (30) tick();
        checkVal("t3SingleDone", doneCnt, 1);
        checkVal("t3Count", obsCount[1], 1);
        checkVal("t3Idle", obsBusy[1], 0);

        // T4: sink stalls on header byte 1 while samples wait at the input
        outReadyCmd = 1'b0;
        pushHeader();
        addSample(256, 1'b1); addSample(-256, 1'b1); addSample(100, 1'b1); addSample(30000, 1'b1);
        startBlock();
        waitOutValid("t4Hdr0Timeout");
        outReadyCmd = 1'b1;
        tick();
        outReadyCmd = 1'b0;
        waitOutValid("t4Hdr1Timeout");
        for (int k = 0; k < 20; k++) begin
            checkVal("t4StallByte", obsByte[1], 0);
            checkVal("t4StallValid", obsValid[1], 1);
            checkVal("t4StallInReady", obsInReady[1], 0);
            checkVal("t4StallEncValid", obsEncValid[1], 0);
            tick();
        end
        outReadyCmd = 1'b1;
        waitDone(2, "t4Block");
        checkVal("t4Count", obsCount[1], 2);

        // T5: enable dropped after the first sample; block still completes
        pushHeader();
        addSample(500, 1'b1); addSample(-300, 1'b1); addSample(1200, 1'b1); addSample(-50, 1'b1);
        b0 = bytesSeen;
        enableCmd = 1'b1;
        for (int k = 0; k < 200 && srcQ.size() > 3; k++) tick();
        enableCmd = 1'b0;
        waitDone(3, "t5Block");
        repeat (10) tick();
        checkVal("t5Bytes", bytesSeen - b0, 6);
        checkVal("t5SrcDrained", srcQ.size(), 0);
        checkVal("t5Idle", obsBusy[1], 0);

        // T6: reset while the core is encoding
        pushHeader();
        addSample(700, 1'b1); addSample(-700, 1'b1); addSample(0, 1'b1); addSample(0, 1'b1);
        startBlock();
        for (int k = 0; k < 200 && !obsEncValid[1]; k++) tick();
        repeat (2) tick();
        reset = 1'b1;
        #1;
        checkVal("t6OutValid", obsValid[1], 0);
        checkVal("t6OutByte", obsByte[1], 0);
        checkVal("t6InReady", obsInReady[1], 0);
        checkVal("t6EncValid", obsEncValid[1], 0);
        checkVal("t6EncSamp", obsEncSamp[1], 0);
        checkVal("t6Busy", obsBusy[1], 0);
        checkVal("t6BlockDone", obsDone[1], 0);
        checkVal("t6BlockCount", obsCount[1], 0);
        expQ.delete(); srcQ.delete();
        refPred = 0; refIdx = 0; refOdd = 1'b0; doneCnt = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        pushHeader();
        addSample(1000, 1'b1); addSample(1000, 1'b1); addSample(-2000, 1'b1); addSample(5, 1'b1);
        startBlock();
        waitDone(1, "t6Block");
        repeat (5) tick();
        checkVal("t6CountAfter", obsCount[1], 1);
        checkVal("scoreboardEmpty", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
